cim_sequencer: RTL and testbench

CIM_SEQUENCER -- requirements
Module: cim_sequencer

---
 rtl/cim_sequencer.sv | 179 +++++++++++++++++
 tb/tb_cim_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cim_sequencer.sv
// Job sequencer for a bank of compute-in-memory arrays: walks the selected arrays
// lowest-first, running col_count+1 fetch/calculate/write passes on each.
module cim_sequencer #(
    parameter int NUM_ARRAY = 16,
    parameter int COL_W     = 4,
    parameter int TMO_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_ARRAY-1:0] array_mask,
    input  logic [COL_W-1:0]     col_count,
    input  logic                 empty_inputfifo,
    input  logic                 full_outputfifo,
    input  logic                 cal_done,
    output logic                 RD_EN_inputfifo,
    output logic                 cal_b,
    output logic                 col_en,
    output logic [NUM_ARRAY-1:0] sel_array,
    output logic                 WR_EN_outputfifo,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PICK  = 3'd1,
        FETCH = 3'd2,
        CAL   = 3'd3,
        WAITC = 3'd4,
        WRITE = 3'd5,
        FIN   = 3'd6
    } state_t;

    localparam logic [NUM_ARRAY-1:0] MASK_ZERO = {NUM_ARRAY{1'b0}};
    localparam logic [NUM_ARRAY-1:0] MASK_ONE  = {{(NUM_ARRAY-1){1'b0}}, 1'b1};
    localparam logic [COL_W-1:0]     PASS_ZERO = {COL_W{1'b0}};
    localparam logic [COL_W-1:0]     PASS_ONE  = {{(COL_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0]     WDOG_ZERO = {TMO_W{1'b0}};
    localparam logic [TMO_W-1:0]     WDOG_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0]     WDOG_MAX  = {TMO_W{1'b1}};

    // Isolates the lowest set bit: v & -v.
    function automatic logic [NUM_ARRAY-1:0] lowest_one(input logic [NUM_ARRAY-1:0] v);
        return v & (~v + MASK_ONE);
    endfunction

    state_t                 state_r, state_s;
    logic [NUM_ARRAY-1:0]   rem_mask_r, rem_mask_s;
    logic [NUM_ARRAY-1:0]   sel_r, sel_s;
    logic [COL_W-1:0]       col_lim_r, col_lim_s;
    logic [COL_W-1:0]       pass_r, pass_s;
    logic [TMO_W-1:0]       wdog_r, wdog_s;
    logic                   err_r, err_s;
    logic                   rd_en_s;
    logic                   wr_en_s;

    // State and job-context registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= IDLE;
            rem_mask_r <= MASK_ZERO;
            sel_r      <= MASK_ZERO;
            col_lim_r  <= PASS_ZERO;
            pass_r     <= PASS_ZERO;
            wdog_r     <= WDOG_ZERO;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            rem_mask_r <= rem_mask_s;
            sel_r      <= sel_s;
            col_lim_r  <= col_lim_s;
            pass_r     <= pass_s;
            wdog_r     <= wdog_s;
            err_r      <= err_s;
        end
    end

    // Next-state, job-context updates and FIFO strobes.
    always_comb begin
        state_s    = state_r;
        rem_mask_s = rem_mask_r;
        sel_s      = sel_r;
        col_lim_s  = col_lim_r;
        pass_s     = pass_r;
        wdog_s     = wdog_r;
        err_s      = err_r;
        rd_en_s    = 1'b0;
        wr_en_s    = 1'b0;

        case (state_r)
            IDLE: begin
                sel_s = MASK_ZERO;
                if (start) begin
                    if (array_mask != MASK_ZERO) begin
                        rem_mask_s = array_mask;
                        col_lim_s  = col_count;
                        err_s      = 1'b0;
                        state_s    = PICK;
                    end else begin
                        state_s = FIN;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            PICK: begin
                sel_s   = lowest_one(rem_mask_r);
                pass_s  = PASS_ZERO;
                state_s = FETCH;
            end
            FETCH: begin
                if (!empty_inputfifo) begin
                    rd_en_s = 1'b1;
                    state_s = CAL;
                end else begin
                    state_s = FETCH;
                end
            end
            CAL: begin
                wdog_s  = WDOG_ZERO;
                state_s = WAITC;
            end
            WAITC: begin
                if (cal_done) begin
                    state_s = WRITE;
                end else begin
                    wdog_s = wdog_r + WDOG_ONE;
                    // Abort the whole job the cycle the watchdog saturates.
                    if (wdog_s == WDOG_MAX) begin
                        err_s   = 1'b1;
                        sel_s   = MASK_ZERO;
                        state_s = FIN;
                    end else begin
                        state_s = WAITC;
                    end
                end
            end
            WRITE: begin
                if (!full_outputfifo) begin
                    wr_en_s = 1'b1;
                    if (pass_r == col_lim_r) begin
                        rem_mask_s = rem_mask_r & ~sel_r;
                        if (rem_mask_s != MASK_ZERO) begin
                            state_s = PICK;
                        end else begin
                            sel_s   = MASK_ZERO;
                            state_s = FIN;
                        end
                    end else begin
                        pass_s  = pass_r + PASS_ONE;
                        state_s = FETCH;
                    end
                end else begin
                    state_s = WRITE;
                end
            end
            FIN: begin
                sel_s   = MASK_ZERO;
                state_s = IDLE;
            end
            default: begin
                sel_s   = MASK_ZERO;
                state_s = IDLE;
            end
        endcase
    end

    assign RD_EN_inputfifo  = rd_en_s;
    assign col_en           = rd_en_s;
    assign WR_EN_outputfifo = wr_en_s;
    assign cal_b            = (state_r != CAL);
    assign busy             = (state_r != IDLE);
    assign done             = (state_r == FIN);
    assign sel_array        = sel_r;
    assign err              = err_r;

endmodule

// File: tb/tb_cim_sequencer.sv
// Directed and randomized jobs for cim_sequencer, checked against a pass-list model
// built from the mask and column count.
module tb_cim_sequencer;
    localparam int NA = 16;
    localparam int CW = 4;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [NA-1:0] array_mask = '0;
    logic [CW-1:0] col_count = '0;
    logic          empty_inputfifo = 1'b1;
    logic          full_outputfifo = 1'b0;
    logic          cal_done = 1'b0;
    logic          RD_EN_inputfifo, cal_b, col_en, WR_EN_outputfifo, busy, done, err;
    logic [NA-1:0] sel_array;

    int   checks = 0;
    int   failures = 0;
    logic err_model = 1'b0;

    always #5 clk = ~clk;

    cim_sequencer #(.NUM_ARRAY(NA), .COL_W(CW), .TMO_W(TW)) dut (
        .clk(clk), .rst(rst), .start(start), .array_mask(array_mask), .col_count(col_count),
        .empty_inputfifo(empty_inputfifo), .full_outputfifo(full_outputfifo), .cal_done(cal_done),
        .RD_EN_inputfifo(RD_EN_inputfifo), .cal_b(cal_b), .col_en(col_en), .sel_array(sel_array),
        .WR_EN_outputfifo(WR_EN_outputfifo), .busy(busy), .done(done), .err(err)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [NA-1:0] obs, input logic [NA-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chkv({tag, "_sel"}, sel_array, '0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_err"}, err, 1'b0);
        chk1({tag, "_cal_b"}, cal_b, 1'b1);
        chk1({tag, "_rd"}, RD_EN_inputfifo, 1'b0);
        chk1({tag, "_wr"}, WR_EN_outputfifo, 1'b0);
        chk1({tag, "_col_en"}, col_en, 1'b0);
    endtask

    // dly: cycles from cal_b low to cal_done pulse (0 = never answer).
    task automatic run_job(input logic [NA-1:0] m, input logic [CW-1:0] cc, input int dly,
                           input int pe, input int pf, input int empty_first,
                           input int full_first, input bit lat_chk);
        logic [NA-1:0] exp_q[$];
        logic [NA-1:0] one_hot;
        int  rd_n = 0, wr_n = 0, cal_n = 0, k = 0;
        int  sched = -1, first_cal = -1, last_rd = 0, cal_cyc = -1, done_k = -1;
        int  passes;
        bit  tmo;
        tmo = (dly == 0) && (m != '0);
        for (int i = 0; i < NA; i++) begin
            if (m[i]) begin
                one_hot = '0;
                one_hot[i] = 1'b1;
                for (int p = 0; p <= int'(cc); p++) exp_q.push_back(one_hot);
            end
        end
        passes = tmo ? 1 : exp_q.size();
        while (done_k < 0 && k < 6000) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b1;
                array_mask = m;
                col_count = cc;
            end else begin
                start = 1'($urandom_range(0, 1));
                array_mask = NA'($urandom);
                col_count = CW'($urandom);
            end
            empty_inputfifo = (k < empty_first) || ($urandom_range(0, 99) < pe);
            full_outputfifo = (first_cal >= 0 && k > first_cal && k <= first_cal + full_first)
                              || ($urandom_range(0, 99) < pf);
            cal_done = (k == sched) || (pe > 0 && $urandom_range(0, 7) == 0);
            if (k == sched && first_cal < 0) first_cal = k;
            #1;
            chk1("col_en_mirrors_rd", col_en, RD_EN_inputfifo);
            chk1("no_pop_when_empty", RD_EN_inputfifo & empty_inputfifo, 1'b0);
            chk1("no_push_when_full", WR_EN_outputfifo & full_outputfifo, 1'b0);
            chk1("busy", busy, k > 0);
            if (RD_EN_inputfifo) begin
                chkv("sel_at_pop", sel_array, (rd_n < exp_q.size()) ? exp_q[rd_n] : '0);
                rd_n++;
                last_rd = k;
            end
            if (!cal_b) begin
                cal_n++;
                cal_cyc = k;
                if (dly > 0) sched = k + dly;
            end
            if (WR_EN_outputfifo) begin
                chkv("sel_at_push", sel_array, (wr_n < exp_q.size()) ? exp_q[wr_n] : '0);
                if (lat_chk) chki("pass_latency", k - last_rd, 3);
                wr_n++;
            end
            if (done) begin
                done_k = k;
                chkv("sel_cleared_in_fin", sel_array, '0);
            end
            k++;
        end
        chk1("done_seen", done_k >= 0, 1'b1);
        chki("pop_total", rd_n, passes);
        chki("cal_total", cal_n, passes);
        chki("push_total", wr_n, tmo ? 0 : passes);
        err_model = tmo ? 1'b1 : ((m != '0) ? 1'b0 : err_model);
        chk1("err_at_done", err, err_model);
        if (tmo) chki("timeout_done_delay", done_k - cal_cyc, 256);
        if (m == '0) chki("degenerate_done_cycle", done_k, 1);
        @(negedge clk);
        start = 1'b0;
        cal_done = 1'b0;
        empty_inputfifo = 1'b0;
        full_outputfifo = 1'b0;
        #1;
        chk1("busy_after_job", busy, 1'b0);
        chk1("done_one_cycle", done, 1'b0);
        chkv("sel_idle", sel_array, '0);
        chk1("err_held_idle", err, err_model);
    endtask

    initial begin
        bit seen;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
        empty_inputfifo = 1'b0;

        run_job(16'h0001, 4'd0, 3, 0, 0, 0, 0, 1'b0);
        run_job(16'h8005, 4'd2, 1, 0, 0, 0, 0, 1'b1);
        run_job(16'h0012, 4'd1, 2, 0, 0, 10, 5, 1'b0);
        run_job(16'h0003, 4'd0, 0, 0, 0, 0, 0, 1'b0);
        run_job(16'h0100, 4'd1, 2, 0, 0, 0, 0, 1'b0);
        run_job(16'h0000, 4'd3, 1, 0, 0, 0, 0, 1'b0);

        // Reset during WAITC.
        @(negedge clk);
        start = 1'b1;
        array_mask = 16'h0006;
        col_count = 4'd1;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (!cal_b) seen = 1'b1;
        end
        chk1("rst_reached_cal", seen, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("midjob_reset");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk1("post_reset_no_done", done, 1'b0);
            chk1("post_reset_no_pop", RD_EN_inputfifo, 1'b0);
            chk1("post_reset_no_push", WR_EN_outputfifo, 1'b0);
        end
        err_model = 1'b0;

        for (int j = 0; j < 6; j++) begin
            run_job(NA'($urandom), CW'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
                    30, 30, 0, 0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
